// File: rtl/sorter_pkg.sv
// sorter_pkg: shared types and constants for the streaming sorter.
//   state_t   - controller states (load frame, sort in place, drain sorted frame)
//   ORD_ASC / ORD_DESC - values of the per-frame sort-order bit
package sorter_pkg;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_SORT,
    ST_DRAIN
  } state_t;

  localparam logic ORD_ASC  = 1'b0;
  localparam logic ORD_DESC = 1'b1;

endpackage

// File: rtl/sorter_stream_if.sv
// sorter_stream_if: stream/status bundle of the sorter.
//   master - the environment: drives desc, in_valid/in_data/in_last, out_ready
//   slave  - the sorter: drives in_ready, out_valid/out_data/out_last, busy, frame_len
// Parameters DATA_W and DEPTH must match the attached sorter_stream instance.
interface sorter_stream_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              desc;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;
  logic [CNT_W-1:0]  frame_len;

  modport master (
    output desc, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy, frame_len
  );

  modport slave (
    input  desc, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, busy, frame_len
  );
endinterface

// File: rtl/sorter_cmp_swap.sv
// sorter_cmp_swap: combinational compare-exchange cell.
//   a, b    - elements at positions i and i+1
//   desc    - 0 ascending, 1 descending
//   enable  - cell participates in the current phase
//   lo, hi  - new values for positions i and i+1 (lo is the "first" slot in
//             the selected order, so it holds the larger key when descending)
// Macro SORTER_SIGNED_EN: compare as two's-complement signed; otherwise unsigned.
// Swaps only on strict inequality so equal keys keep their order.
module sorter_cmp_swap #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              desc,
  input  logic              enable,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] hi
);
  import sorter_pkg::*;

  logic a_gt_b;
  logic a_lt_b;
  logic swap;

  always_comb begin
`ifdef SORTER_SIGNED_EN
    a_gt_b = $signed(a) > $signed(b);
    a_lt_b = $signed(a) < $signed(b);
`else
    a_gt_b = a > b;
    a_lt_b = a < b;
`endif
    swap = enable && ((desc == ORD_DESC) ? a_lt_b : a_gt_b);
    lo   = swap ? b : a;
    hi   = swap ? a : b;
  end

endmodule

// File: rtl/sorter_stream.sv
// sorter_stream: loads a frame of up to DEPTH words, sorts it in place with an
// odd-even transposition network (DEPTH phases), then streams it out.
//   clk, rstn - clock (rising edge), asynchronous active-low reset
//   s         - sorter_stream_if.slave: input stream (desc sampled on the final
//               word), output stream with backpressure, busy, frame_len
// Macro SORTER_SIGNED_EN (in sorter_cmp_swap): signed element compare.
module sorter_stream #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input logic            clk,
  input logic            rstn,
  sorter_stream_if.slave s
);
  import sorter_pkg::*;

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  state_t            state;
  logic [DATA_W-1:0] mem     [DEPTH];
  logic [DATA_W-1:0] nxt     [DEPTH];
  logic [DATA_W-1:0] lo_w    [DEPTH-1];
  logic [DATA_W-1:0] hi_w    [DEPTH-1];
  logic [DEPTH-2:0]  cell_en;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  rd;
  logic [CNT_W-1:0]  rd_nxt;
  logic [CNT_W-1:0]  phase;
  logic [CNT_W-1:0]  frame_len_q;
  logic              ord_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              out_last_q;
  logic              busy_q;
  logic [DATA_W-1:0] out_data_q;

  assign s.in_ready  = in_ready_q;
  assign s.out_valid = out_valid_q;
  assign s.out_last  = out_last_q;
  assign s.out_data  = out_data_q;
  assign s.busy      = busy_q;
  assign s.frame_len = frame_len_q;

  assign rd_nxt = rd + CNT_W'(1);

  // Even phases enable cells 0,2,4..., odd phases 1,3,5...; cells reaching
  // past the frame are held off so stale entries never move.
  always_comb begin
    cell_en = '0;
    for (int unsigned i = 0; i < DEPTH - 1; i++) begin
      cell_en[i] = (state == ST_SORT) && (i[0] == phase[0]) &&
                   (CNT_W'(i + 1) < frame_len_q);
    end
  end

  for (genvar g = 0; g < DEPTH - 1; g++) begin : g_cell
    sorter_cmp_swap #(.DATA_W(DATA_W)) u_cell (
      .a      (mem[g]),
      .b      (mem[g+1]),
      .desc   (ord_q),
      .enable (cell_en[g]),
      .lo     (lo_w[g]),
      .hi     (hi_w[g])
    );
  end

  // Enabled cells of one phase cover disjoint pairs, so each slot has at most
  // one writer.
  always_comb begin
    for (int unsigned j = 0; j < DEPTH; j++) nxt[j] = mem[j];
    for (int unsigned i = 0; i < DEPTH - 1; i++) begin
      if (cell_en[i]) begin
        nxt[i]   = lo_w[i];
        nxt[i+1] = hi_w[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_LOAD;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_data_q  <= '0;
      frame_len_q <= '0;
      cnt         <= '0;
      rd          <= '0;
      phase       <= '0;
      ord_q       <= ORD_ASC;
      for (int unsigned j = 0; j < DEPTH; j++) mem[j] <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (s.in_valid) begin
            mem[cnt[IDX_W-1:0]] <= s.in_data;
            if (s.in_last || cnt == CNT_W'(DEPTH - 1)) begin
              frame_len_q <= cnt + CNT_W'(1);
              ord_q       <= s.desc;
              cnt         <= '0;
              phase       <= '0;
              in_ready_q  <= 1'b0;
              busy_q      <= 1'b1;
              state       <= ST_SORT;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        ST_SORT: begin
          for (int unsigned j = 0; j < DEPTH; j++) mem[j] <= nxt[j];
          if (phase == CNT_W'(DEPTH - 1)) begin
            // First output word is taken straight from the final phase's
            // result so out_valid rises without an extra cycle.
            state       <= ST_DRAIN;
            out_valid_q <= 1'b1;
            out_data_q  <= nxt[0];
            out_last_q  <= (frame_len_q == CNT_W'(1));
            rd          <= '0;
          end else begin
            phase <= phase + CNT_W'(1);
          end
        end
        ST_DRAIN: begin
          if (s.out_ready) begin
            if (out_last_q) begin
              state       <= ST_LOAD;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              busy_q      <= 1'b0;
              in_ready_q  <= 1'b1;
              cnt         <= '0;
            end else begin
              rd          <= rd_nxt;
              out_data_q  <= mem[rd_nxt[IDX_W-1:0]];
              out_last_q  <= (rd_nxt == frame_len_q - CNT_W'(1));
            end
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_sorter_stream.sv
// tb_sorter_stream: directed bench for sorter_stream. A 32-bit and an 8-bit
// instance run in lockstep from the same stimulus; the 8-bit one is checked on
// the signed/duplicate frame, whose expectation depends on SORTER_SIGNED_EN.
module tb_sorter_stream;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        desc, in_valid, in_last, out_ready;
  logic [31:0] in_data;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sorter_stream_if #(.DATA_W(32), .DEPTH(DEPTH)) bus32 ();
  sorter_stream_if #(.DATA_W(8),  .DEPTH(DEPTH)) bus8 ();

  assign bus32.desc      = desc;
  assign bus32.in_valid  = in_valid;
  assign bus32.in_data   = in_data;
  assign bus32.in_last   = in_last;
  assign bus32.out_ready = out_ready;
  assign bus8.desc       = desc;
  assign bus8.in_valid   = in_valid;
  assign bus8.in_data    = in_data[7:0];
  assign bus8.in_last    = in_last;
  assign bus8.out_ready  = out_ready;

  sorter_stream #(.DATA_W(32), .DEPTH(DEPTH)) u_dut (
    .clk  (clk),
    .rstn (rstn),
    .s    (bus32.slave)
  );

  sorter_stream #(.DATA_W(8), .DEPTH(DEPTH)) u_dut8 (
    .clk  (clk),
    .rstn (rstn),
    .s    (bus8.slave)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents n words back to back; h returns the cycle count right after the
  // final handshake edge.
  task automatic send_frame(input logic [31:0] d[8], input int n, input logic dsc,
                            input logic use_last, output int h);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1;
      in_data  = d[k];
      in_last  = use_last && (k == n - 1);
      desc     = dsc;
      check_val("in_ready_load", bus32.in_ready, 1);
      @(posedge clk); #1;
      h = cyc;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  task automatic drain(input logic [31:0] e32[8], input logic [7:0] e8[8], input int n,
                       input logic chk8, input logic bp, input int h);
    int          budget;
    int          idx;
    int          k;
    logic        stall;
    logic [31:0] held_d;
    logic        held_l;
    logic [3:0]  bp_pat;
    bp_pat    = 4'b1001;  // out_ready sequence 1,0,0,1 (bit k%4)
    out_ready = 1'b0;
    budget    = 0;
    while (!bus32.out_valid && budget < 4 * DEPTH) begin
      @(posedge clk); #1;
      budget++;
    end
    // out_valid appears DEPTH edges after the final handshake edge,
    // i.e. in the (DEPTH+1)-th cycle after the handshake cycle.
    check_val("latency", cyc - h, DEPTH);
    idx   = 0;
    k     = 0;
    stall = 1'b0;
    while (idx < n && k < 8 * DEPTH) begin
      out_ready = bp ? bp_pat[k % 4] : 1'b1;
      if (stall) begin
        check_val("stall_data", bus32.out_data, held_d);
        check_val("stall_last", bus32.out_last, held_l);
      end
      check_val("out_valid", bus32.out_valid, 1);
      check_val("in_ready_drain", bus32.in_ready, 0);
      check_val("busy_drain", bus32.busy, 1);
      if (out_ready) begin
        check_val($sformatf("out_data[%0d]", idx), bus32.out_data, e32[idx]);
        check_val($sformatf("out_last[%0d]", idx), bus32.out_last, (idx == n - 1));
        if (chk8) check_val($sformatf("out8_data[%0d]", idx), bus8.out_data, e8[idx]);
        idx++;
        stall = 1'b0;
      end else begin
        stall  = 1'b1;
        held_d = bus32.out_data;
        held_l = bus32.out_last;
      end
      @(posedge clk); #1;
      k++;
    end
    out_ready = 1'b0;
    check_val("drain_count", idx, n);
    check_val("in_ready_after", bus32.in_ready, 1);
    check_val("out_valid_after", bus32.out_valid, 0);
    check_val("busy_after", bus32.busy, 0);
  endtask

  initial begin
    logic [31:0] d[8];
    logic [31:0] e[8];
    logic [7:0]  e8[8];
    int          h;

    desc = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; in_data = '0;
    e8 = '{default: 8'h00};
    #12;
    check_val("rst_in_ready", bus32.in_ready, 1);
    check_val("rst_out_valid", bus32.out_valid, 0);
    check_val("rst_out_last", bus32.out_last, 0);
    check_val("rst_busy", bus32.busy, 0);
    check_val("rst_out_data", bus32.out_data, 0);
    check_val("rst_frame_len", bus32.frame_len, 0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Ascending full frame with in_last on word 8
    d = '{5, 3, 9, 1, 7, 2, 8, 4};
    e = '{1, 2, 3, 4, 5, 7, 8, 9};
    send_frame(d, 8, 1'b0, 1'b1, h);
    check_val("t1_busy", bus32.busy, 1);
    check_val("t1_frame_len", bus32.frame_len, 8);
    drain(e, e8, 8, 1'b0, 1'b0, h);

    // Descending, frame closes at DEPTH words without in_last
    e = '{9, 8, 7, 5, 4, 3, 2, 1};
    send_frame(d, 8, 1'b1, 1'b0, h);
    check_val("t2_in_ready", bus32.in_ready, 0);
    check_val("t2_frame_len", bus32.frame_len, 8);
    drain(e, e8, 8, 1'b0, 1'b0, h);

    // Partial frame of 3 words
    d = '{30, 10, 20, 0, 0, 0, 0, 0};
    e = '{10, 20, 30, 0, 0, 0, 0, 0};
    send_frame(d, 3, 1'b0, 1'b1, h);
    check_val("t3_frame_len", bus32.frame_len, 3);
    drain(e, e8, 3, 1'b0, 1'b0, h);

    // Backpressure during drain
    d = '{5, 3, 9, 1, 7, 2, 8, 4};
    e = '{1, 2, 3, 4, 5, 7, 8, 9};
    send_frame(d, 8, 1'b0, 1'b1, h);
    drain(e, e8, 8, 1'b0, 1'b1, h);

    // Reset during SORT phase 3, then a 2-word frame
    send_frame(d, 8, 1'b0, 1'b1, h);
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check_val("mid_rst_in_ready", bus32.in_ready, 1);
    check_val("mid_rst_busy", bus32.busy, 0);
    check_val("mid_rst_out_valid", bus32.out_valid, 0);
    check_val("mid_rst_frame_len", bus32.frame_len, 0);
    check_val("mid_rst_out_data", bus32.out_data, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;
    d = '{2, 1, 0, 0, 0, 0, 0, 0};
    e = '{1, 2, 0, 0, 0, 0, 0, 0};
    send_frame(d, 2, 1'b0, 1'b1, h);
    check_val("t5_frame_len", bus32.frame_len, 2);
    drain(e, e8, 2, 1'b0, 1'b0, h);

    // Signed compare and duplicate keys (8-bit instance checked)
    d = '{32'hFF, 32'h01, 32'h01, 32'h80, 0, 0, 0, 0};
    e = '{32'h01, 32'h01, 32'h80, 32'hFF, 0, 0, 0, 0};
`ifdef SORTER_SIGNED_EN
    e8 = '{8'h80, 8'hFF, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
`else
    e8 = '{8'h01, 8'h01, 8'h80, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
`endif
    send_frame(d, 4, 1'b0, 1'b1, h);
    check_val("t6_frame_len8", bus8.frame_len, 4);
    drain(e, e8, 4, 1'b1, 1'b0, h);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sorter_stream.md
Name: sorter_stream

Overview:
- Parametrised next-generation sorter: accepts a frame of up to DEPTH words over a valid/ready stream and sorts it in place with an odd-even transposition network.
- Sort order is selectable (ascending/descending) per frame; the sorted frame is then streamed out with backpressure support.
- Replaces the fixed 8x32 controller/datapath sorter as the sorting engine of the top-level subsystem.

Parameters:
- DATA_W, 32, data word width in bits.
- DEPTH, 8, maximum frame length in words; must be >= 2.
- CNT_W, $clog2(DEPTH+1), width of the element counters; derived, not overridden.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- desc  in  1  sort order: 0 = ascending, 1 = descending; sampled on the final input handshake of a frame.
- in_valid  in  1  input word valid.
- in_ready  out  1  block accepts an input word.
- in_data  in  DATA_W  input word.
- in_last  in  1  marks the final word of a frame.
- out_valid  out  1  sorted word valid.
- out_ready  in  1  downstream accepts a word.
- out_data  out  DATA_W  sorted word.
- out_last  out  1  marks the final sorted word.
- busy  out  1  high in SORT and DRAIN.
- frame_len  out  CNT_W  number of words in the current frame; valid in SORT and DRAIN.

Behaviour:
- Reset (async assert, sync release): state = LOAD; in_ready = 1; out_valid, out_last, busy = 0; out_data = 0; frame_len = 0; all element registers = 0.
- States: LOAD -> SORT -> DRAIN -> LOAD.
- LOAD:
  - in_ready = 1.
  - On in_valid && in_ready, write in_data to reg[cnt] and increment cnt.
  - Leave for SORT when the handshake carries in_last, or when cnt reaches DEPTH (the DEPTH-th word ends the frame even without in_last).
  - frame_len and the latched order bit are captured on that handshake.
- SORT:
  - in_ready = 0; busy = 1.
  - Runs for exactly DEPTH cycles, phase p = 0..DEPTH-1.
  - Even phases compare/exchange pairs (0,1), (2,3), ...; odd phases compare/exchange pairs (1,2), (3,4), ....
  - A pair (i, i+1) participates only if i+1 < frame_len; entries at or beyond frame_len are untouched.
  - Swap only on strict inequality (ascending: reg[i] > reg[i+1]; descending: reg[i] < reg[i+1]), so equal keys keep input order.
  - Comparison is unsigned by default.
  - frame_len = 1 still spends DEPTH cycles, with no swaps.
- DRAIN:
  - out_valid = 1; out_data = reg[rd]; out_last = (rd == frame_len-1).
  - rd increments on out_valid && out_ready.
  - out_data and out_last are held stable while out_valid && !out_ready.
  - After the last handshake: state = LOAD, out_valid = 0, cnt = 0, in_ready = 1 on the next cycle.
- Latency: the first out_valid is asserted DEPTH+1 cycles after the cycle of the final input handshake.
- in_valid during SORT or DRAIN is ignored; no word is accepted.
- Inputs are don't-care while not handshaking; desc is don't-care except on the final handshake.
- Reset mid-SORT or mid-DRAIN discards the frame; the block returns to the reset state immediately.
- The block holds a single frame; no overlap between LOAD of frame n+1 and DRAIN of frame n.

Optional Feature:
- Macro SORTER_SIGNED_EN.
- Defined: element comparison is two's-complement signed over DATA_W bits.
- Undefined: unsigned comparison.
- Ports and timing are identical in both builds.

Decomposition:
- Package sorter_pkg: state enum (ST_LOAD, ST_SORT, ST_DRAIN) and the sort-order constants (ORD_ASC = 0, ORD_DESC = 1).
- Sub-module sorter_cmp_swap: a combinational compare-exchange cell.
  - Parameter: DATA_W. Inputs: a, b, desc, enable. Outputs: lo, hi.
  - Carries the SORTER_SIGNED_EN compare.
  - Instantiated DEPTH-1 times by a generate loop; phase parity selects which cells are enabled.

Test Plan:
- Ascending full frame (DEPTH=8, desc=0): input 5,3,9,1,7,2,8,4 with in_last on the 8th word -> output 1,2,3,4,5,7,8,9; out_last on the 8th word; first out_valid 9 cycles after the last input handshake.
- Descending with auto-termination: same data, desc=1, in_last never asserted -> frame closes at 8 words; output 9,8,7,5,4,3,2,1.
- Partial frame: 3 words 30,10,20 with in_last on the 3rd -> frame_len = 3; output 10,20,30; out_last on 30; in_ready = 1 one cycle after the last output handshake.
- Backpressure: out_ready toggled 1,0,0,1,... during DRAIN -> out_data stable while stalled; no word lost or duplicated; in_ready stays 0 until the drain completes.
- Reset mid-SORT: assert rstn = 0 at phase 3 -> outputs take reset values immediately; a following 2-word frame 2,1 sorts to 1,2.
- Signed/duplicates: DATA_W=8, input 0xFF,0x01,0x01,0x80 ascending -> without SORTER_SIGNED_EN: 0x01,0x01,0x80,0xFF; with it: 0x80,0xFF,0x01,0x01; the two equal 0x01 keys keep their input order.
